// File: rtl/branch_predict_resolve.sv
// Branch unit: the IF-stage BTB lookup is combinational, and the ID-stage resolve/flush is combinational.
// Predictor state and statistics update one clock edge after resolve; a stalled ID freezes all state and suppresses flush.
module branch_predict_resolve #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 4,
  parameter int STAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] if_pc,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  input  logic                 id_valid,
  input  logic                 id_stall,
  input  logic [WORD_SIZE-1:0] id_pc,
  input  logic [WORD_SIZE-1:0] id_a,
  input  logic [WORD_SIZE-1:0] id_b,
  input  logic [2:0]           id_branch_type,
  input  logic [WORD_SIZE-1:0] id_target,
  input  logic                 id_pred_taken,
  input  logic [WORD_SIZE-1:0] id_pred_target,
  output logic                 bcond,
  output logic                 flush,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic [STAT_W-1:0]    n_branch,
  output logic [STAT_W-1:0]    n_mispredict
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = WORD_SIZE - IDX_BITS;

  typedef struct packed {
    logic                 vld;
    logic [TAG_W-1:0]     tag;
    logic [WORD_SIZE-1:0] target;
    logic [1:0]           ctr;
  } btb_entry_t;

  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];
  logic [STAT_W-1:0] n_branch_q, n_branch_d;
  logic [STAT_W-1:0] n_mispredict_q, n_mispredict_d;

  logic [IDX_BITS-1:0] if_idx, id_idx;
  logic                if_hit, id_hit, is_branch, resolve;

  assign if_idx = if_pc[IDX_BITS-1:0];
  assign id_idx = id_pc[IDX_BITS-1:0];
  assign if_hit = btb_q[if_idx].vld && (btb_q[if_idx].tag == if_pc[WORD_SIZE-1:IDX_BITS]);
  assign id_hit = btb_q[id_idx].vld && (btb_q[id_idx].tag == id_pc[WORD_SIZE-1:IDX_BITS]);

  assign pred_taken  = if_hit && btb_q[if_idx].ctr[1];
  assign pred_target = if_hit ? btb_q[if_idx].target : if_pc + WORD_SIZE'(1);

  always_comb begin
    bcond     = 1'b0;
    is_branch = 1'b1;
    case (id_branch_type)
      3'd1:    bcond = (id_a != id_b);
      3'd2:    bcond = (id_a == id_b);
      3'd3:    bcond = !id_a[WORD_SIZE-1] && (id_a != '0);
      3'd4:    bcond = id_a[WORD_SIZE-1];
      3'd5:    bcond = 1'b1;
      default: is_branch = 1'b0;
    endcase
  end

  // reset_n gates resolve so a branch sitting in ID while reset is low can never flush
  assign resolve     = id_valid && !id_stall && is_branch && reset_n;
  assign flush       = resolve && ((bcond != id_pred_taken) ||
                                   (bcond && (id_target != id_pred_target)));
  assign redirect_pc = bcond ? id_target : id_pc + WORD_SIZE'(1);

  always_comb begin
    btb_d          = btb_q;
    n_branch_d     = n_branch_q;
    n_mispredict_d = n_mispredict_q;
    if (resolve) begin
      if (n_branch_q != {STAT_W{1'b1}}) n_branch_d = n_branch_q + STAT_W'(1);
      if (flush && (n_mispredict_q != {STAT_W{1'b1}}))
        n_mispredict_d = n_mispredict_q + STAT_W'(1);
      if (id_hit) begin
        if (bcond) begin
          if (btb_q[id_idx].ctr != 2'b11) btb_d[id_idx].ctr = btb_q[id_idx].ctr + 2'b01;
          btb_d[id_idx].target = id_target;
        end else if (btb_q[id_idx].ctr != 2'b00) begin
          btb_d[id_idx].ctr = btb_q[id_idx].ctr - 2'b01;
        end
      end else if (bcond) begin
        // allocate weakly-taken; a not-taken miss leaves the entry alone
        btb_d[id_idx].vld    = 1'b1;
        btb_d[id_idx].tag    = id_pc[WORD_SIZE-1:IDX_BITS];
        btb_d[id_idx].target = id_target;
        btb_d[id_idx].ctr    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
      n_branch_q     <= '0;
      n_mispredict_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i] <= btb_d[i];
      n_branch_q     <= n_branch_d;
      n_mispredict_q <= n_mispredict_d;
    end
  end

  assign n_branch     = n_branch_q;
  assign n_mispredict = n_mispredict_q;

endmodule
